// File: rtl/raizing_prog_packer.sv
`default_nettype none
// ============================================================================
//  Module   : raizing_prog_packer
//  Purpose  : Packs a byte-wide ROM download stream into 16-bit masked SDRAM
//             programming writes through a small write queue.
//  Revision : 1.0  initial release
// ============================================================================
module raizing_prog_packer #(
    parameter int AW    = 22,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          BYTE_WR,
    input  logic [AW:0]   BYTE_ADDR,
    input  logic [1:0]    BYTE_BA,
    input  logic [7:0]    BYTE_DATA,
    input  logic          FLUSH,
    output logic          FULL,
    output logic          BUSY,
    output logic          OVERRUN,
    output logic [AW-1:0] PROG_ADDR,
    output logic [15:0]   PROG_DATA,
    output logic [1:0]    PROG_MASK,
    output logic [1:0]    PROG_BA,
    output logic          PROG_WE,
    input  logic          PROG_RDY
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_EW = AW + 2 + 16 + 2;
    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_FULL_LVL  = c_CW'(DEPTH - 2);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_WRITE = 1'b1;

    // Pending word; lane-valid bit 1 is the even byte (data[15:8]), bit 0 the odd byte.
    logic [AW-1:0]   r_pend_addr;
    logic [1:0]      r_pend_ba;
    logic [15:0]     r_pend_data;
    logic [1:0]      r_pend_lv;

    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_overrun;
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;

    logic [AW-1:0]   w_byte_word;
    logic            w_hit;
    logic [AW-1:0]   w_nx_addr;
    logic [1:0]      w_nx_ba;
    logic [15:0]     w_nx_data;
    logic [1:0]      w_nx_lv;
    logic            w_push_a;
    logic            w_push_b;
    logic [c_EW-1:0] w_push_a_ent;
    logic [c_EW-1:0] w_push_b_ent;
    logic            w_a_acc;
    logic            w_b_acc;
    logic [c_CW-1:0] w_free;
    logic [c_PW-1:0] w_wptr1;
    logic            w_load;
    logic            w_pop;

    // Queue entry layout: {word address, bank, data, mask}; mask bit set = lane suppressed.
    function automatic logic [c_EW-1:0] f_pack(
        input logic [AW-1:0] addr,
        input logic [1:0]    ba,
        input logic [15:0]   data,
        input logic [1:0]    lv
    );
        return {addr, ba, data, ~lv};
    endfunction

    assign w_byte_word = BYTE_ADDR[AW:1];
    assign w_hit       = (|r_pend_lv) && (r_pend_addr == w_byte_word) && (r_pend_ba == BYTE_BA);

    always_comb begin
        w_nx_addr    = r_pend_addr;
        w_nx_ba      = r_pend_ba;
        w_nx_data    = r_pend_data;
        w_nx_lv      = r_pend_lv;
        w_push_a     = 1'b0;
        w_push_a_ent = f_pack(r_pend_addr, r_pend_ba, r_pend_data, r_pend_lv);
        w_push_b     = 1'b0;
        w_push_b_ent = w_push_a_ent;
        if (BYTE_WR) begin
            if (!w_hit) begin
                w_push_a  = |r_pend_lv;
                w_nx_addr = w_byte_word;
                w_nx_ba   = BYTE_BA;
                w_nx_data = '0;
                w_nx_lv   = '0;
            end
            if (BYTE_ADDR[0]) begin
                w_nx_data[7:0] = BYTE_DATA;
                w_nx_lv[0]     = 1'b1;
            end else begin
                w_nx_data[15:8] = BYTE_DATA;
                w_nx_lv[1]      = 1'b1;
            end
            if (&w_nx_lv) begin
                w_push_a     = 1'b1;
                w_push_a_ent = f_pack(w_nx_addr, w_nx_ba, w_nx_data, w_nx_lv);
                w_nx_lv      = '0;
            end
        end
        // A flush goes behind whatever the same-cycle byte already pushed.
        if (FLUSH && (|w_nx_lv)) begin
            if (w_push_a) begin
                w_push_b     = 1'b1;
                w_push_b_ent = f_pack(w_nx_addr, w_nx_ba, w_nx_data, w_nx_lv);
            end else begin
                w_push_a     = 1'b1;
                w_push_a_ent = f_pack(w_nx_addr, w_nx_ba, w_nx_data, w_nx_lv);
            end
            w_nx_lv = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pend_addr <= '0;
            r_pend_ba   <= '0;
            r_pend_data <= '0;
            r_pend_lv   <= '0;
        end else begin
            r_pend_addr <= w_nx_addr;
            r_pend_ba   <= w_nx_ba;
            r_pend_data <= w_nx_data;
            r_pend_lv   <= w_nx_lv;
        end
    end

    // A same-cycle pop frees the head slot; the head was already copied into PROG_*.
    assign w_free  = c_DEPTH - r_count + c_CW'(w_pop);
    assign w_a_acc = w_push_a && (w_free != '0);
    assign w_b_acc = w_push_b && (w_free > (w_a_acc ? c_CW'(1) : c_CW'(0)));
    assign w_wptr1 = r_wptr + c_PW'(1);

    always_ff @(posedge CLK) begin
        if (w_a_acc) r_mem[r_wptr]  <= w_push_a_ent;
        if (w_b_acc) r_mem[w_wptr1] <= w_push_b_ent;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_wptr    <= r_wptr + c_PW'(w_a_acc) + c_PW'(w_b_acc);
            r_rptr    <= r_rptr + c_PW'(w_pop);
            r_count   <= r_count + c_CW'(w_a_acc) + c_CW'(w_b_acc) - c_CW'(w_pop);
            r_overrun <= r_overrun | (w_push_a & ~w_a_acc) | (w_push_b & ~w_b_acc);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= c_S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (r_count != '0) w_state_nxt = c_S_WRITE;
            c_S_WRITE: if (PROG_RDY)      w_state_nxt = c_S_IDLE;
            default:                      w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_load = (r_state == c_S_IDLE) && (r_count != '0);
        w_pop  = (r_state == c_S_WRITE) && PROG_RDY;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PROG_ADDR <= '0;
            PROG_BA   <= '0;
            PROG_DATA <= '0;
            PROG_MASK <= '0;
            PROG_WE   <= 1'b0;
        end else if (w_load) begin
            {PROG_ADDR, PROG_BA, PROG_DATA, PROG_MASK} <= r_mem[r_rptr];
            PROG_WE <= 1'b1;
        end else if (w_pop) begin
            PROG_WE <= 1'b0;
        end
    end

    assign FULL    = (r_count >= c_FULL_LVL);
    assign BUSY    = (|r_pend_lv) | (r_count != '0) | PROG_WE;
    assign OVERRUN = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_raizing_prog_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_raizing_prog_packer
//  Purpose  : Scoreboard bench for raizing_prog_packer with a byte-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_raizing_prog_packer;

    logic        CLK;
    logic        RESET_N;
    logic        BYTE_WR;
    logic [22:0] BYTE_ADDR;
    logic [1:0]  BYTE_BA;
    logic [7:0]  BYTE_DATA;
    logic        FLUSH;
    logic        FULL;
    logic        BUSY;
    logic        OVERRUN;
    logic [21:0] PROG_ADDR;
    logic [15:0] PROG_DATA;
    logic [1:0]  PROG_MASK;
    logic [1:0]  PROG_BA;
    logic        PROG_WE;
    logic        PROG_RDY;

    raizing_prog_packer #(.AW(22), .DEPTH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .BYTE_WR(BYTE_WR), .BYTE_ADDR(BYTE_ADDR),
        .BYTE_BA(BYTE_BA), .BYTE_DATA(BYTE_DATA), .FLUSH(FLUSH), .FULL(FULL),
        .BUSY(BUSY), .OVERRUN(OVERRUN), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
        .PROG_MASK(PROG_MASK), .PROG_BA(PROG_BA), .PROG_WE(PROG_WE), .PROG_RDY(PROG_RDY)
    );

    typedef struct {
        logic [21:0] addr;
        logic [1:0]  ba;
        logic [15:0] data;
        logic [1:0]  mask;
    } wr_t;

    wr_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Byte-level model: lane 0 = even byte, lane 1 = odd byte of the current word.
    bit          mv[2];
    logic [7:0]  mb[2];
    logic [21:0] mw;
    logic [1:0]  mba;
    int          m_budget = -1;

    bit rdy_hold  = 1'b0;
    bit rand_idle = 1'b1;
    int rdy_fixed = -1;
    int wcnt = 0;
    int dly  = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic m_emit();
        wr_t e;
        if (!(mv[0] || mv[1])) return;
        e.addr = mw;
        e.ba   = mba;
        e.data = {mb[0], mb[1]};
        e.mask = {!mv[0], !mv[1]};
        if (m_budget != 0) begin
            sb.push_back(e);
            if (m_budget > 0) m_budget--;
        end
        mv[0] = 1'b0;
        mv[1] = 1'b0;
    endtask

    task automatic m_byte(input logic [22:0] a, input logic [1:0] ba, input logic [7:0] d);
        int lane;
        lane = int'(a[0]);
        if ((mv[0] || mv[1]) && ((a[22:1] != mw) || (ba != mba))) m_emit();
        mw = a[22:1];
        mba = ba;
        mb[lane] = d;
        mv[lane] = 1'b1;
        if (mv[0] && mv[1]) m_emit();
    endtask

    task automatic drive(input bit wr, input logic [22:0] a, input logic [1:0] ba,
                         input logic [7:0] d, input bit fl);
        BYTE_WR   = wr;
        BYTE_ADDR = a;
        BYTE_BA   = ba;
        BYTE_DATA = d;
        FLUSH     = fl;
        if (wr) m_byte(a, ba, d);
        if (fl) m_emit();
    endtask

    task automatic cycle(input bit wr, input logic [22:0] a, input logic [1:0] ba,
                         input logic [7:0] d, input bit fl);
        @(negedge CLK);
        drive(wr, a, ba, d, fl);
    endtask

    task automatic idle();
        cycle(1'b0, 23'($urandom), 2'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while ((sb.size() != 0 || BUSY) && c < maxc) begin
            @(negedge CLK);
            c++;
        end
        chk("drain_timeout", 64'(c >= maxc), 64'd0);
    endtask

    // PROG_RDY responder: random latency, optional stall, random noise while idle.
    always @(posedge CLK) begin
        #1;
        if (!RESET_N || rdy_hold) begin
            PROG_RDY = 1'b0;
            wcnt = 0;
        end else if (!PROG_WE) begin
            PROG_RDY = rand_idle ? 1'($urandom) : 1'b0;
            wcnt = 0;
            dly = (rdy_fixed >= 0) ? rdy_fixed : int'($urandom_range(0, 3));
        end else begin
            wcnt++;
            PROG_RDY = (wcnt > dly);
        end
    end

    // Monitor: checks each accepted write against the scoreboard head.
    bit          we_prev  = 1'b0;
    bit          last_acc = 1'b0;
    logic [41:0] hold;
    wr_t         mon_e;
    logic [15:0] dm;

    always @(negedge CLK) begin
        if (last_acc) chk("we_gap", 64'(PROG_WE), 64'd0);
        last_acc = 1'b0;
        if (PROG_WE) begin
            if (!we_prev) hold = {PROG_ADDR, PROG_DATA, PROG_MASK, PROG_BA};
            else chk("we_hold", 64'({PROG_ADDR, PROG_DATA, PROG_MASK, PROG_BA}), 64'(hold));
            if (PROG_RDY) begin
                last_acc = 1'b1;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             PROG_ADDR, PROG_DATA);
                end else begin
                    mon_e = sb.pop_front();
                    dm = {{8{~mon_e.mask[1]}}, {8{~mon_e.mask[0]}}};
                    chk("prog_addr", 64'(PROG_ADDR), 64'(mon_e.addr));
                    chk("prog_ba",   64'(PROG_BA),   64'(mon_e.ba));
                    chk("prog_mask", 64'(PROG_MASK), 64'(mon_e.mask));
                    chk("prog_data", 64'(PROG_DATA & dm), 64'(mon_e.data & dm));
                end
            end
        end
        we_prev = PROG_WE;
    end

    logic [22:0] ra;
    logic [1:0]  rba;
    int          hi;

    initial begin
        RESET_N = 1'b0;
        PROG_RDY = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_we",      64'(PROG_WE),   64'd0);
        chk("reset_busy",    64'(BUSY),      64'd0);
        chk("reset_full",    64'(FULL),      64'd0);
        chk("reset_overrun", 64'(OVERRUN),   64'd0);
        chk("reset_outs",    64'({PROG_ADDR, PROG_DATA, PROG_MASK, PROG_BA}), 64'd0);
        RESET_N = 1'b1;

        // Two bytes of one word, fixed three-cycle write latency.
        rand_idle = 1'b0;
        rdy_fixed = 2;
        cycle(1'b1, 23'h000, 2'd1, 8'h12, 1'b0);
        cycle(1'b1, 23'h001, 2'd1, 8'h34, 1'b0);
        idle();
        chk("lat_we_low",  64'(PROG_WE), 64'd0);
        chk("lat_busy",    64'(BUSY),    64'd1);
        idle();
        chk("lat_we_high", 64'(PROG_WE), 64'd1);
        hi = 1;
        while (PROG_WE && hi < 20) begin
            @(negedge CLK);
            if (PROG_WE) hi++;
        end
        chk("we_len", 64'(hi), 64'd3);
        drain(50);
        rdy_fixed = -1;
        rand_idle = 1'b1;

        // Odd byte then flush.
        cycle(1'b1, 23'h005, 2'd0, 8'hAB, 1'b0);
        cycle(1'b0, 23'h000, 2'd0, 8'h00, 1'b1);
        idle();
        drain(50);
        chk("flush_busy", 64'(BUSY), 64'd0);

        // Non-adjacent even bytes, then byte+flush in the same cycle (two pushes).
        cycle(1'b1, 23'h010, 2'd0, 8'h5C, 1'b0);
        cycle(1'b1, 23'h020, 2'd0, 8'hC5, 1'b0);
        cycle(1'b0, 23'h000, 2'd0, 8'h00, 1'b1);
        cycle(1'b1, 23'h031, 2'd2, 8'h77, 1'b0);
        cycle(1'b1, 23'h040, 2'd2, 8'h88, 1'b1);
        idle();
        drain(80);

        // Random stream that respects FULL.
        ra = '0;
        rba = '0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (!FULL && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 3) == 0) ra = 23'($urandom_range(0, 31));
                else ra = ra + 23'd1;
                if ($urandom_range(0, 7) == 0) rba = 2'($urandom);
                drive(($urandom_range(0, 9) != 0), ra, rba, 8'($urandom),
                      ($urandom_range(0, 9) == 0));
            end else begin
                drive(1'b0, 23'($urandom), 2'($urandom), 8'($urandom), 1'b0);
            end
        end
        cycle(1'b0, '0, '0, '0, 1'b1);
        idle();
        drain(200);
        chk("rand_overrun", 64'(OVERRUN), 64'd0);

        // Stalled sink with 12 bytes: only the first four words fit.
        rdy_hold = 1'b1;
        m_budget = 4;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 23'h100 + 23'(k), 2'd2, 8'($urandom), 1'b0);
            if (k == 3) chk("full_cnt1", 64'(FULL), 64'd0);
            if (k == 4) chk("full_cnt2", 64'(FULL), 64'd1);
        end
        idle();
        idle();
        chk("overrun_set", 64'(OVERRUN), 64'd1);
        m_budget = -1;
        rdy_hold = 1'b0;
        drain(200);
        chk("overrun_sticky", 64'(OVERRUN), 64'd1);

        // Reset while a write is pending and three words are queued.
        rdy_hold = 1'b1;
        for (int k = 0; k < 6; k++) cycle(1'b1, 23'h200 + 23'(k), 2'd3, 8'($urandom), 1'b0);
        idle();
        idle();
        chk("pre_rst_we",   64'(PROG_WE), 64'd1);
        chk("pre_rst_full", 64'(FULL),    64'd1);
        @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        chk("rst_we",      64'(PROG_WE), 64'd0);
        chk("rst_outs",    64'({PROG_ADDR, PROG_DATA, PROG_MASK, PROG_BA}), 64'd0);
        chk("rst_busy",    64'(BUSY),    64'd0);
        chk("rst_full",    64'(FULL),    64'd0);
        chk("rst_overrun", 64'(OVERRUN), 64'd0);
        sb.delete();
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        rdy_hold = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle();
            chk("post_rst_busy", 64'(BUSY), 64'd0);
        end

        // First byte after reset, with flush in the same cycle.
        cycle(1'b1, 23'h007, 2'd3, 8'h5A, 1'b1);
        idle();
        chk("post_rst_accept", 64'(BUSY), 64'd1);
        drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/raizing_prog_packer.md
RAIZING_PROG_PACKER -- requirements
Module: raizing_prog_packer

Interface
REQ-001 SHALL have parameter AW, default 22: SDRAM word-address width.
REQ-002 SHALL have parameter DEPTH, default 4: write-queue entries, power of two, >=4.
REQ-003 SHALL have port CLK  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port BYTE_WR  in  1  one-cycle strobe: byte valid.
REQ-006 SHALL have port BYTE_ADDR  in  AW+1  bank-relative byte address.
REQ-007 SHALL have port BYTE_BA  in  2  target SDRAM bank.
REQ-008 SHALL have port BYTE_DATA  in  8  byte value.
REQ-009 SHALL have port FLUSH  in  1  one-cycle strobe: push partial word (end of download).
REQ-010 SHALL have port FULL  out  1  upstream shall not strobe BYTE_WR/FLUSH while high.
REQ-011 SHALL have port BUSY  out  1  data held anywhere in block.
REQ-012 SHALL have port OVERRUN  out  1  sticky: byte or flush dropped.
REQ-013 SHALL have ports PROG_ADDR out AW, PROG_DATA out 16, PROG_MASK out 2, PROG_BA out 2, PROG_WE out 1  SDRAM programming write.
REQ-014 SHALL have port PROG_RDY  in  1  SDRAM write accepted.

Function
REQ-015 SHALL keep one pending-word register: word address (BYTE_ADDR>>1), bank, 16-bit data, two lane-valid bits.
REQ-016 SHALL place even byte (BYTE_ADDR[0]=0) in data[15:8], odd byte in data[7:0].
REQ-017 On BYTE_WR matching pending word address and bank: merge byte into its lane; rewrite of a valid lane overwrites it.
REQ-018 On BYTE_WR with pending valid and mismatching address or bank: push pending to queue, then pending = new byte alone.
REQ-019 When both lanes valid after a merge: push pending that same clock edge, clear pending.
REQ-020 On FLUSH: apply any same-cycle BYTE_WR first (REQ-017..019), then push remaining pending if valid; up to two pushes per cycle.
REQ-021 PROG_MASK per entry, bit=1 suppresses lane: both lanes 2'b00, even only 2'b01, odd only 2'b10.
REQ-022 Queue: DEPTH entries, read/write pointers wrap modulo DEPTH, count 0..DEPTH.
REQ-023 FULL = count >= DEPTH-2, combinational from registered count.
REQ-024 A push into a completely full queue SHALL be dropped, set OVERRUN, never corrupt stored entries; OVERRUN clears only on reset.
REQ-025 Output FSM states IDLE, WRITE.
REQ-026 IDLE: if queue non-empty, register head into PROG_ADDR/DATA/MASK/BA, set PROG_WE=1, go WRITE.
REQ-027 WRITE: hold PROG_* stable and PROG_WE=1 until PROG_RDY sampled high; then PROG_WE=0, pop head, go IDLE.
REQ-028 Minimum one cycle PROG_WE low between consecutive writes; throughput max one word per 2+ cycles.
REQ-029 Latency: BYTE_WR completing a word at edge n -> queued at n -> PROG_WE high after edge n+1.
REQ-030 Push and pop in same cycle: count unchanged.
REQ-031 BUSY = pending valid | count!=0 | PROG_WE.
REQ-032 PROG_RDY while IDLE SHALL be ignored.

Reset
REQ-033 RESET_N low SHALL immediately clear pending, pointers, count, OVERRUN, PROG_WE, PROG_ADDR/DATA/MASK/BA to 0, FSM to IDLE.
REQ-034 Reset mid-write SHALL drop PROG_WE at once; queued data lost.
REQ-035 After RESET_N rises, first BYTE_WR accepted at next edge.

Verification
REQ-036 Bytes 0x12@0x000, 0x34@0x001, BA=1, PROG_RDY after 3 cycles -> one write ADDR=0, DATA=0x1234, MASK=00, BA=1, WE held exactly until RDY.
REQ-037 Byte 0xAB@0x005 then FLUSH -> DATA[7:0]=0xAB, ADDR=2, MASK=10; BUSY low after RDY.
REQ-038 Bytes @0x010, @0x020 (non-adjacent) then FLUSH -> two writes MASK=01 ADDR 0x08, 0x10 in order.
REQ-039 PROG_RDY held low, stream 12 sequential bytes ignoring FULL -> FULL at count 2, OVERRUN set, first 4 words intact and emitted in order once RDY released.
REQ-040 RESET_N low while PROG_WE high and queue count 3 -> all outputs 0 same cycle; after release BUSY=0, no stale write.
